// File: rtl/noc_sender_arbiter_pkg.sv
// Shared types and helpers for the NoC sender arbiter.
// noc_types carries the node address type and the arbiter state encoding;
// noc_functions holds helpers that do not depend on N_CLIENTS.
package noc_types;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } e_arb_state;
endpackage

package noc_functions;
  // Increment with wrap at n; works for non-power-of-2 counts.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/noc_sender_arbiter_if.sv
// Sender-side handshake bundle: enable/flush/ack plus the packet fields.
// master = arbiter driving the sender, slave = the sender itself.
interface noc_sender_arbiter_if
  import noc_types::*;
#(
  parameter int PACKET_BITS  = 16,
  parameter int PADDING_BITS = 8
);
  logic                    snd_enable;
  logic                    snd_flush;
  addr_t                   snd_dst_addr;
  logic [PADDING_BITS-1:0] snd_padding;
  logic [PACKET_BITS-1:0]  snd_packet;
  logic                    snd_ack;

  modport master (
    output snd_enable, snd_flush, snd_dst_addr, snd_padding, snd_packet,
    input  snd_ack
  );

  modport slave (
    input  snd_enable, snd_flush, snd_dst_addr, snd_padding, snd_packet,
    output snd_ack
  );
endinterface

// File: rtl/noc_sender_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, with
// wrap. The pointer register lives in the parent.
module noc_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          vld
);
  int j;

  // Scan N positions starting at ptr; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        vld      = 1'b1;
        idx      = IW'(j);
        grant[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_sender_arbiter.sv
// Round-robin arbiter sharing one NoC packet sender among N_CLIENTS
// requesters. The grant is held from request through flush; the owner's
// fields are muxed to the sender and the sender's ack is routed back to the
// owner only.
// Optional: define NOC_ARB_STATS_EN for per-client completed-packet counters.
module noc_sender_arbiter
  import noc_types::*;
  import noc_functions::*;
#(
  parameter int N_CLIENTS    = 4,
  parameter int PACKET_BITS  = 16,
  parameter int PADDING_BITS = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_CLIENTS-1:0]                    cl_req,
  input  logic [N_CLIENTS-1:0]                    cl_flush,
  input  addr_t [N_CLIENTS-1:0]                   cl_dst_addr,
  input  logic [N_CLIENTS-1:0][PADDING_BITS-1:0]  cl_padding,
  input  logic [N_CLIENTS-1:0][PACKET_BITS-1:0]   cl_packet,
  output logic [N_CLIENTS-1:0]                    cl_ack,
  output logic [N_CLIENTS-1:0]                    cl_grant,
  noc_sender_arbiter_if.master                    snd
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [N_CLIENTS-1:0][15:0]              stat_cnt
`endif
);
  localparam int IW = $clog2(N_CLIENTS);

  e_arb_state           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;

  logic [N_CLIENTS-1:0] arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;
  logic                 release_w;

  noc_rr_arbiter #(.N(N_CLIENTS), .IW(IW)) u_rr (
    .req   (cl_req),
    .ptr   (rr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .vld   (arb_vld)
  );

  // Owner's flush in DONE ends the transaction; other clients' flushes never matter.
  assign release_w = (state_q == DONE) && cl_flush[idx_q];

  // Next-state: pick in IDLE, wait for ack in BUSY, wait for owner flush in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: if (arb_vld) begin
        state_d = BUSY;
        idx_d   = arb_idx;
        grant_d = arb_grant;
      end
      BUSY: if (snd.snd_ack) state_d = DONE;
      DONE: if (release_w) begin
        state_d = IDLE;
        rr_d    = IW'(wrap_inc(int'(idx_q), N_CLIENTS));
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and owner registers; rst aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  // Output decode from registered state; fields are zero while idle.
  always_comb begin
    cl_grant         = (state_q != IDLE) ? grant_q : '0;
    cl_ack           = (state_q == DONE && snd.snd_ack) ? grant_q : '0;
    snd.snd_enable   = (state_q == BUSY);
    snd.snd_flush    = release_w;
    snd.snd_dst_addr = '0;
    snd.snd_padding  = '0;
    snd.snd_packet   = '0;
    if (state_q != IDLE) begin
      snd.snd_dst_addr = cl_dst_addr[idx_q];
      snd.snd_padding  = cl_padding[idx_q];
      snd.snd_packet   = cl_packet[idx_q];
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic [N_CLIENTS-1:0][15:0] stat_q, stat_d;

  // Count a completed packet for the owner on DONE->IDLE, saturating.
  always_comb begin
    stat_d = stat_q;
    if (release_w) stat_d[idx_q] = sat_inc16(stat_q[idx_q]);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_cnt = stat_q;
`endif

  // The owner must keep requesting until it sees its ack; the FSM carries on anyway.
  a_req_held : assert property (@(posedge clk) disable iff (rst)
    (state_q == BUSY) |-> cl_req[idx_q]);
endmodule

// File: tb/tb_noc_sender_arbiter.sv
// Self-checking bench for noc_sender_arbiter. A small sender model acks one
// cycle after enable and drops ack on flush; expected grants are queued when
// requests are driven and popped when the sender is enabled.
module tb_noc_sender_arbiter;
  import noc_types::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]        cl_req = '0, cl_flush = '0;
  addr_t [N-1:0]       cl_dst_addr = '0;
  logic [N-1:0][7:0]   cl_padding = '0;
  logic [N-1:0][15:0]  cl_packet = '0;
  logic [N-1:0]        cl_ack, cl_grant;
  logic                ack_r;
`ifdef NOC_ARB_STATS_EN
  logic [N-1:0][15:0]  stat_cnt;
`endif

  noc_sender_arbiter_if #(.PACKET_BITS(16), .PADDING_BITS(8)) snd ();

  noc_sender_arbiter #(.N_CLIENTS(N), .PACKET_BITS(16), .PADDING_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cl_req      (cl_req),
    .cl_flush    (cl_flush),
    .cl_dst_addr (cl_dst_addr),
    .cl_padding  (cl_padding),
    .cl_packet   (cl_packet),
    .cl_ack      (cl_ack),
    .cl_grant    (cl_grant),
    .snd         (snd)
`ifdef NOC_ARB_STATS_EN
    ,
    .stat_cnt    (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Sender model: ack one cycle into enable, hold until flush.
  always @(posedge clk or posedge rst) begin
    if (rst)                ack_r <= 1'b0;
    else if (snd.snd_flush) ack_r <= 1'b0;
    else if (snd.snd_enable) ack_r <= 1'b1;
  end
  assign snd.snd_ack = ack_r;

  typedef struct {
    int          idx;
    addr_t       dst;
    logic [7:0]  pad;
    logic [15:0] pkt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic set_client(input int c, input logic [3:0] x, input logic [3:0] y,
                            input logic [7:0] pad, input logic [15:0] pkt);
    cl_dst_addr[c] = '{x: x, y: y};
    cl_padding[c]  = pad;
    cl_packet[c]   = pkt;
  endtask

  task automatic push_exp(input int c);
    exp_t e;
    e.idx = c; e.dst = cl_dst_addr[c]; e.pad = cl_padding[c]; e.pkt = cl_packet[c];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cl_req = '0; cl_flush = '0; sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Serve the next queued transaction. Called at the negedge where its
  // request is visible. inject is OR-ed into cl_req on the first BUSY cycle;
  // clr is cleared from cl_req when the owner flushes.
  task automatic serve(input logic [N-1:0] clr, input logic [N-1:0] inject, output int lat);
    exp_t e;
    logic [N-1:0] oh;
    int n;
    lat = -1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL sb_empty: queue empty, required an entry"); return;
    end
    e = sb.pop_front();
    oh = N'(1) << e.idx;
    n = 0;
    @(negedge clk);
    while (!snd.snd_enable && n < 20) begin @(negedge clk); n++; end
    lat = n;
    if (!snd.snd_enable) begin
      n_fail++; $display("FAIL enable_timeout: client %0d never enabled", e.idx); return;
    end
    n_cmp++;
    if (cl_grant !== oh) begin
      n_fail++; $display("FAIL grant: got %b required %b", cl_grant, oh);
    end
    n_cmp++;
    if ({snd.snd_dst_addr, snd.snd_padding, snd.snd_packet} !== {e.dst, e.pad, e.pkt}) begin
      n_fail++; $display("FAIL fields: got %h/%h/%h required %h/%h/%h", snd.snd_dst_addr,
                         snd.snd_padding, snd.snd_packet, e.dst, e.pad, e.pkt);
    end
    cl_req = cl_req | inject;
    n = 0;
    while (cl_ack == '0 && n < 20) begin
      @(negedge clk); n++;
      n_cmp++;
      if (cl_grant !== oh || snd.snd_dst_addr !== e.dst || snd.snd_packet !== e.pkt) begin
        n_fail++; $display("FAIL hold: grant %b dst %h pkt %h required %b %h %h",
                           cl_grant, snd.snd_dst_addr, snd.snd_packet, oh, e.dst, e.pkt);
      end
    end
    n_cmp++;
    if (cl_ack !== oh || snd.snd_enable !== 1'b0) begin
      n_fail++; $display("FAIL ack: cl_ack %b enable %b required %b 0", cl_ack, snd.snd_enable, oh);
    end
    cl_flush = oh;
    cl_req = cl_req & ~clr;
    #1;
    n_cmp++;
    if (snd.snd_flush !== 1'b1) begin
      n_fail++; $display("FAIL snd_flush: got %b required 1", snd.snd_flush);
    end
    @(negedge clk);
    cl_flush = '0;
    n_cmp++;
    if (cl_grant !== '0 || snd.snd_enable !== 1'b0) begin
      n_fail++; $display("FAIL idle_gap: grant %b enable %b required 0 0", cl_grant, snd.snd_enable);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_client(0, 4'd3, 4'd4, 8'hAA, 16'h1234);
    set_client(1, 4'd5, 4'd6, 8'hBB, 16'h5678);
    cl_req = 4'b0011;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cl_ack, cl_grant, snd.snd_enable, snd.snd_flush, snd.snd_dst_addr,
         snd.snd_padding, snd.snd_packet} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: grant %b enable %b dst %h pkt %h required all 0",
                         cl_grant, snd.snd_enable, snd.snd_dst_addr, snd.snd_packet);
    end
    cl_req = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    set_client(2, 4'd1, 4'd2, 8'h5A, 16'hC0DE);
    cl_req = 4'b0100;
    push_exp(2);
    serve(4'b0100, '0, lat);
    n_cmp++;
    if (lat !== 0) begin
      n_fail++; $display("FAIL single_latency: extra cycles %0d required 0", lat);
    end
  endtask

  task automatic test_round_robin();
    int lat;
    do_reset();
    for (int c = 0; c < N; c++)
      set_client(c, 4'(c), 4'(c + 8), 8'(8'h10 + c), 16'(16'hA000 + c * 16'h111));
    cl_req = 4'b1111;
    for (int c = 0; c < N; c++) push_exp(c);
    push_exp(0);
    for (int k = 0; k < 4; k++) serve('0, '0, lat);
    serve(4'b1111, '0, lat);
  endtask

  task automatic test_contention();
    int lat;
    do_reset();
    set_client(3, 4'd7, 4'd1, 8'h33, 16'h3333);
    set_client(1, 4'd2, 4'd9, 8'h11, 16'h1111);
    cl_req = 4'b1000;
    push_exp(3);
    push_exp(1);
    serve(4'b1000, 4'b0010, lat);
    serve(4'b0010, '0, lat);
  endtask

  task automatic test_ignored_flush();
    exp_t e;
    int n;
    do_reset();
    set_client(0, 4'd6, 4'd6, 8'h66, 16'h6666);
    set_client(2, 4'd1, 4'd1, 8'h22, 16'h2222);
    cl_req = 4'b0001;
    push_exp(0);
    e = sb.pop_front();
    n = 0;
    while (cl_ack == '0 && n < 20) begin @(negedge clk); n++; end
    cl_flush = 4'b0100;
    #1;
    n_cmp++;
    if (snd.snd_flush !== 1'b0 || cl_ack !== 4'b0001) begin
      n_fail++; $display("FAIL foreign_flush: snd_flush %b cl_ack %b required 0 0001",
                         snd.snd_flush, cl_ack);
    end
    @(negedge clk);
    n_cmp++;
    if (cl_grant !== 4'b0001 || cl_ack !== 4'b0001 || snd.snd_dst_addr !== e.dst) begin
      n_fail++; $display("FAIL stay_done: grant %b ack %b dst %h required 0001 0001 %h",
                         cl_grant, cl_ack, snd.snd_dst_addr, e.dst);
    end
    cl_flush = 4'b0001;
    cl_req = '0;
    #1;
    n_cmp++;
    if (snd.snd_flush !== 1'b1) begin
      n_fail++; $display("FAIL owner_flush: got %b required 1", snd.snd_flush);
    end
    @(negedge clk);
    cl_flush = '0;
    n_cmp++;
    if (cl_grant !== '0) begin
      n_fail++; $display("FAIL release: grant %b required 0", cl_grant);
    end
  endtask

  task automatic test_reset_busy();
    int lat;
    do_reset();
    set_client(0, 4'd0, 4'd5, 8'h01, 16'h0F0F);
    set_client(1, 4'd1, 4'd5, 8'h02, 16'h1F1F);
    set_client(2, 4'd2, 4'd5, 8'h03, 16'h2F2F);
    set_client(3, 4'd3, 4'd5, 8'h04, 16'h3F3F);
    cl_req = 4'b0010;
    push_exp(1);
    serve(4'b0010, '0, lat);
    cl_req = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (snd.snd_enable !== 1'b1 || cl_grant !== 4'b1000) begin
      n_fail++; $display("FAIL pre_abort: enable %b grant %b required 1 1000", snd.snd_enable, cl_grant);
    end
    rst = 1'b1;
    cl_req = '0;
    @(negedge clk);
    n_cmp++;
    if ({cl_ack, cl_grant, snd.snd_enable, snd.snd_flush, snd.snd_dst_addr,
         snd.snd_padding, snd.snd_packet} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: grant %b enable %b dst %h required all 0",
                         cl_grant, snd.snd_enable, snd.snd_dst_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    cl_req = 4'b0101;
    push_exp(0);
    push_exp(2);
    serve(4'b0001, '0, lat);
    serve(4'b0100, '0, lat);
  endtask

`ifdef NOC_ARB_STATS_EN
  task automatic test_stats();
    int lat;
    logic [N-1:0][15:0] fv;
    do_reset();
    set_client(1, 4'd4, 4'd4, 8'h44, 16'h4444);
    for (int k = 0; k < 3; k++) begin
      cl_req = 4'b0010;
      push_exp(1);
      serve(4'b0010, '0, lat);
    end
    n_cmp++;
    if (stat_cnt !== {16'd0, 16'd0, 16'd3, 16'd0}) begin
      n_fail++; $display("FAIL stat_count: got %h required 0000000000030000", stat_cnt);
    end
    fv = '0;
    fv[1] = 16'hFFFF;
    force dut.stat_q = fv;
    @(negedge clk);
    release dut.stat_q;
    cl_req = 4'b0010;
    push_exp(1);
    serve(4'b0010, '0, lat);
    n_cmp++;
    if (stat_cnt[1] !== 16'hFFFF) begin
      n_fail++; $display("FAIL stat_saturate: got %h required ffff", stat_cnt[1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_ignored_flush();
    test_reset_busy();
`ifdef NOC_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/noc_sender_arbiter.md
Name: noc_sender_arbiter

Overview:
- Shares one NoC serial packet sender (enable/flush/ack handshake, one packet per transaction) among N_CLIENTS local requesters.
- Round-robin grant; holds the grant for the whole packet, from header request through flush.
- Muxes the granted client's dst_addr/padding/packet to the sender and routes the sender's ack back to that client only.
- Sits between a node's local producers and its single injection sender.

Parameters:
- N_CLIENTS, 4, number of requesters, ≥2.
- PACKET_BITS, 16, packet payload width, passed through to the sender.
- PADDING_BITS, 8, header padding width, passed through to the sender.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cl_req  in  N_CLIENTS  per-client transmit request; held high until that client's cl_ack
- cl_flush  in  N_CLIENTS  per-client release after cl_ack
- cl_dst_addr  in  N_CLIENTS x addr_t  per-client destination
- cl_padding  in  N_CLIENTS x PADDING_BITS  per-client padding
- cl_packet  in  N_CLIENTS x PACKET_BITS  per-client payload
- cl_ack  out  N_CLIENTS  one-hot packet-sent indication
- cl_grant  out  N_CLIENTS  one-hot current owner, zero when idle
- snd_enable  out  1  to sender enable
- snd_flush  out  1  to sender flush
- snd_dst_addr  out  addr_t  muxed destination
- snd_padding  out  PADDING_BITS  muxed padding
- snd_packet  out  PACKET_BITS  muxed payload
- snd_ack  in  1  sender packet-sent indication

Behaviour:
- Reset values:
  - state=IDLE, grant index 0, rr pointer 0.
  - All outputs 0; mux outputs 0 when no grant.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any cl_req is set, pick the first set bit searching from rr pointer upward, with wrap.
  - Register the winner; go to BUSY next cycle.
  - No outputs asserted in IDLE.
- BUSY:
  - cl_grant one-hot on the winner.
  - snd_enable=1; mux outputs carry the winner's fields.
  - Stays in BUSY until snd_ack=1, then goes to DONE.
  - Sender reject/retry is invisible here: enable stays high.
- DONE:
  - cl_ack[winner] mirrors snd_ack; snd_enable=0; fields stay muxed (stable).
  - snd_flush = cl_flush[winner].
  - When cl_flush[winner]=1: go to IDLE next cycle and set rr pointer to (winner+1) mod N_CLIENTS.
- Latency:
  - Request at cycle t gives snd_enable at t+1.
  - Flush at cycle f allows a new grant decision at f+1 and snd_enable at f+2.
  - Minimum one IDLE cycle between packets.
- Simultaneous requests: round-robin order from the pointer. A just-served client has the lowest priority next time.
- Requests arriving mid-transaction are pending only; no preemption.
- cl_req[winner] falling in BUSY is a protocol violation: assertion. The FSM continues regardless; a packet in flight cannot be aborted.
- cl_flush from non-granted clients is ignored in all states.
- snd_ack while in IDLE: ignored.
- Reset mid-transaction returns to IDLE immediately; the sender is reset by the same rst.
- rr pointer width is $clog2(N_CLIENTS). Wrap uses mod N_CLIENTS, including non-power-of-2 counts.

Optional Feature:
- Macro NOC_ARB_STATS_EN.
- When defined:
  - Adds output stat_cnt, N_CLIENTS x 16 bits.
  - Per-client count of completed packets, incremented on the DONE→IDLE transition.
  - Saturates at 16'hFFFF; reset to 0.
- When undefined: port and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package noc_types: addr_t (existing) and e_arb_state {IDLE, BUSY, DONE}.
- N_CLIENTS-independent helpers stay in noc_functions.
- One sub-module, noc_rr_arbiter:
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, valid.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single request: cl_req=4'b0100, dst=(1,2). Required: snd_enable 1 cycle later with snd_dst_addr=(1,2). Sender acks: cl_ack=4'b0100. Flush: snd_flush pulse; cl_grant=0 next cycle.
- All four request continuously from reset: grants in order 0,1,2,3,0. Each packet's snd_packet equals the owner's cl_packet.
- Contention while busy: client 1 requests during client 3's BUSY. No change to snd_* fields; client 1 is granted after client 3's flush.
- Ignored flush: cl_flush[2]=1 while client 0 is in DONE. No snd_flush, state stays DONE; cl_flush[0] then releases.
- Reset during BUSY with snd_ack low: all outputs 0 next cycle. Next grant starts at client 0.
- With NOC_ARB_STATS_EN: 3 packets from client 1 give stat_cnt[1]=3 and others 0. Forcing the counter to 16'hFFFF and sending one more packet leaves it at 16'hFFFF.
